demux_1_n_deser: RTL and testbench



---
 rtl/demux_1_n_deser_pkg.sv | 22 ++
 rtl/demux_sel_counter.sv | 41 ++++
 rtl/demux_1_n_deser.sv | 77 +++++++
 tb/tb_demux_1_n_deser.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_1_n_deser_pkg.sv
// Shared definitions for the serial-to-parallel 1:2^N demultiplexer.
// Latency: n/a (types and helper functions only).
// Backpressure: n/a.
package demux_1_n_deser_pkg;

    localparam int DEFAULT_N = 3;

    // The only two effective states: collecting with no word held, or collecting while one is held.
    typedef enum logic {
        COLLECT      = 1'b0,
        COLLECT_HOLD = 1'b1
    } deser_state_e;

    function automatic int word_width(input int n);
        return 1 << n;
    endfunction

    function automatic int next_sel(input int sel, input int w);
        return (sel + 1) % w;
    endfunction

endpackage

// File: rtl/demux_sel_counter.sv
// Lane-index counter: N-bit modulo-2^N up-counter with enable and synchronous clear.
// Latency: sel advances on the edge where en is high; wrap is combinational (en on the last lane).
// Backpressure: none; the counter simply holds while en is low.
module demux_sel_counter
    import demux_1_n_deser_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [N-1:0] sel,
    output logic         wrap
);

    localparam int             W        = word_width(N);
    localparam logic [N-1:0]   SEL_LAST = N'(W - 1);

    logic [N-1:0] sel_nxt;

    always_comb begin
        sel_nxt = sel;
        if (en) begin
            sel_nxt = N'(next_sel(int'(sel), W));
        end
    end

    assign wrap = en && (sel == SEL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= '0;
        end else if (clr) begin
            sel <= '0;
        end else begin
            sel <= sel_nxt;
        end
    end

endmodule

// File: rtl/demux_1_n_deser.sv
// Serial-to-parallel 1:2^N demux: bit k of each frame lands in out_data[k], word handed off on valid/ready.
// Latency: out_valid rises on the edge that accepts the last bit of a frame.
// Backpressure: only the frame-completing bit stalls while a previous word is still unconsumed.
module demux_1_n_deser
    import demux_1_n_deser_pkg::*;
#(
    parameter  int N = DEFAULT_N,
    localparam int W = word_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_bit,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sel
);

    localparam logic [N-1:0] SEL_LAST = N'(W - 1);

    // The last lane is never stored: it goes straight into out_data with the completing bit.
    logic [W-2:0]  acc;
    logic          acc_en;
    logic          wrap;
    deser_state_e  state;

    assign state    = out_valid ? COLLECT_HOLD : COLLECT;
    assign in_ready = !((sel == SEL_LAST) && (state == COLLECT_HOLD) && !out_ready);
    assign acc_en   = in_valid && in_ready;

    demux_sel_counter #(
        .N (N)
    ) u_sel_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (acc_en),
        .sel   (sel),
        .wrap  (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (wrap) begin
            acc <= '0;
        end else if (acc_en) begin
            for (int k = 0; k < W - 1; k++) begin
                if (sel == N'(k)) begin
                    acc[k] <= in_bit;
                end
            end
        end
    end

    // A completing word may replace one being consumed on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (clr) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (wrap) begin
            out_data  <= {in_bit, acc};
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux_1_n_deser.sv
// Directed bench for demux_1_n_deser: one N=3 instance and one N=2 instance.
module tb_demux_1_n_deser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;

    logic       in_bit, in_valid, out_ready;
    logic       in_ready, out_valid;
    logic [7:0] out_data;
    logic [2:0] sel;

    logic       b_in_bit, b_in_valid, b_out_ready;
    logic       b_in_ready, b_out_valid;
    logic [3:0] b_out_data;
    logic [1:0] b_sel;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] words [3];

    always #5 clk = ~clk;

    demux_1_n_deser #(.N(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel)
    );

    demux_1_n_deser #(.N(2)) dut_n2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_bit    (b_in_bit),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .sel       (b_sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
        in_bit   = 1'bx;
    endtask

    task automatic push_range(input logic [7:0] w, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            push(w[k]);
        end
    endtask

    task automatic b_push(input logic b);
        b_in_valid = 1'b1;
        b_in_bit   = b;
        tick();
        b_in_valid = 1'b0;
        b_in_bit   = 1'bx;
    endtask

    initial begin
        words[0] = 8'hCF;
        words[1] = 8'h5A;
        words[2] = 8'hFF;

        rst_n = 1'b0; clr = 1'b0;
        in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_bit = 1'b0; b_out_ready = 1'b1;

        // reset state, before any clock edge
        #1;
        chk("rst_sel",       32'(sel), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data), 0);
        #12 rst_n = 1'b1;
        #1;
        chk("rst_in_ready",  32'(in_ready), 1);

        // consecutive frame 1,1,1,1,0,0,1,1
        tick();
        push_range(8'hCF, 0, 7);
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_out_data",  32'(out_data), 32'hCF);
        chk("t1_sel",       32'(sel), 0);
        tick();
        chk("t1_pulse_end", 32'(out_valid), 0);

        // gap of three idle cycles after bit 4
        push_range(8'hCF, 0, 3);
        for (int g = 0; g < 3; g++) begin
            tick();
            chk("t2_sel_hold", 32'(sel), 4);
            chk("t2_no_valid", 32'(out_valid), 0);
        end
        push_range(8'hCF, 4, 7);
        chk("t2_out_valid", 32'(out_valid), 1);
        chk("t2_out_data",  32'(out_data), 32'hCF);
        tick();

        // held word with backpressure on the completing bit
        out_ready = 1'b0;
        push_range(8'hCF, 0, 7);
        chk("t3_held_valid", 32'(out_valid), 1);
        push_range(8'h5A, 0, 6);
        chk("t3_sel7",       32'(sel), 7);
        chk("t3_held_data",  32'(out_data), 32'hCF);
        chk("t3_in_ready0",  32'(in_ready), 0);
        in_valid = 1'b1; in_bit = 1'b0;
        tick();
        chk("t3_stall_sel",  32'(sel), 7);
        chk("t3_stall_data", 32'(out_data), 32'hCF);
        out_ready = 1'b1;
        #1;
        chk("t3_in_ready1",  32'(in_ready), 1);
        tick();
        in_valid = 1'b0; in_bit = 1'bx;
        chk("t3_new_valid",  32'(out_valid), 1);
        chk("t3_new_data",   32'(out_data), 32'h5A);
        chk("t3_sel_wrap",   32'(sel), 0);
        tick();
        chk("t3_drained",    32'(out_valid), 0);

        // back-to-back frames: out_valid only after every 8th bit
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 8; k++) begin
                push(words[f][k]);
                chk("t4_pulse", 32'(out_valid), (k == 7) ? 1 : 0);
                if (k == 7) begin
                    chk("t4_data", 32'(out_data), 32'(words[f]));
                end
            end
        end
        tick();
        chk("t4_drained", 32'(out_valid), 0);

        // clr after five bits discards the partial word
        push_range(8'hFF, 0, 4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_clr_sel",   32'(sel), 0);
        chk("t5_clr_valid", 32'(out_valid), 0);
        chk("t5_clr_data",  32'(out_data), 0);
        push_range(8'h3C, 0, 2);
        chk("t5_partial_valid", 32'(out_valid), 0);
        chk("t5_partial_sel",   32'(sel), 3);
        push_range(8'h3C, 3, 7);
        chk("t5_valid", 32'(out_valid), 1);
        chk("t5_data",  32'(out_data), 32'h3C);

        // asynchronous reset mid-frame while a word is held
        out_ready = 1'b0;
        push_range(8'h5A, 0, 2);
        chk("t6_pre_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_sel",   32'(sel), 0);
        chk("t6_async_valid", 32'(out_valid), 0);
        chk("t6_async_data",  32'(out_data), 0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        push_range(8'h3C, 0, 7);
        chk("t6_valid", 32'(out_valid), 1);
        chk("t6_data",  32'(out_data), 32'h3C);
        tick();

        // N=2 instance: bits 0,1,1,0
        chk("n2_in_ready", 32'(b_in_ready), 1);
        b_push(1'b0);
        b_push(1'b1);
        b_push(1'b1);
        chk("n2_sel3",     32'(b_sel), 3);
        chk("n2_no_valid", 32'(b_out_valid), 0);
        b_push(1'b0);
        chk("n2_valid", 32'(b_out_valid), 1);
        chk("n2_data",  32'(b_out_data), 32'h6);
        chk("n2_wrap",  32'(b_sel), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
